// File: rtl/uart_tx_arb_pkg.sv
// Shared FSM type, parameter defaults and small index helpers for the
// round-robin arbiter that feeds one uart_tx.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int NREQ_DEF      = 4;
  localparam int TO_CYCLES_DEF = 20000;
  localparam int BAUD_RST_DEF  = 868;

  localparam logic [15:0] BAUD_MIN = 16'd16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side handshake bundle: per-requester valid/byte in, one-hot ready out.
interface uart_tx_arb_if
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) ();

  logic [NREQ-1:0]   req_valid_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_ready_o;

  modport master (
    output req_valid_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] slot;
  logic          hit;

  // Walk the slots in priority order; only the first hit is recorded.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    slot = '0;
    hit  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      slot      = IW'((int'(ptr) + i >= NREQ) ? int'(ptr) + i - NREQ : int'(ptr) + i);
      hit       = !any && req[slot];
      gnt[slot] = gnt[slot] | hit;
      idx       = hit ? slot : idx;
      any       = any | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte requesters, with a
// per-frame timeout and an IDLE-only baud divisor update.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int  NREQ      = NREQ_DEF,
  parameter int  TO_CYCLES = TO_CYCLES_DEF,
  parameter int  BAUD_RST  = BAUD_RST_DEF,
  localparam int IW        = idx_width(NREQ),
  localparam int CW        = $clog2(TO_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_tx_arb_if.slave  req,
  input  logic [15:0]   baud_div_i,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  output logic [15:0]   baud_div_o,
  input  logic          tx_done_tick_i,
  output logic          busy_o,
  output logic [IW-1:0] grant_id_o,
  output logic          done_o,
  output logic          err_o
);

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic            finish_done;
  logic            finish_err;
  logic [7:0]      sel_byte;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req.req_valid_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state decode; ready is combinational so the accept lands in the same IDLE cycle.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    ready       = '0;
    finish_done = 1'b0;
    finish_err  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && !rst_i) begin
          accept     = 1'b1;
          ready      = pick_gnt;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        // A done tick beats a simultaneous timeout.
        if (tx_done_tick_i) begin
          finish_done = 1'b1;
          state_next  = IDLE;
        end else if (cnt == CW'(TO_CYCLES - 1)) begin
          finish_err = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte mux driven by the one-hot grant.
  always_comb begin
    sel_byte = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      sel_byte = sel_byte | ({8{pick_gnt[k]}} & req.req_data_i[8*k +: 8]);
    end
  end

  assign req.req_ready_o = ready;
  assign tx_start_o      = (state == START);
  assign busy_o          = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latched frame, pointer, timeout counter, pulses and baud divisor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      cnt        <= '0;
      tx_data_o  <= 8'h00;
      grant_id_o <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      baud_div_o <= 16'(BAUD_RST);
    end else begin
      done_o <= finish_done;
      err_o  <= finish_err;
      if (accept) begin
        tx_data_o  <= sel_byte;
        grant_id_o <= pick_idx;
      end
      if (finish_done || finish_err) begin
        rr_ptr <= IW'(wrap_inc(int'(grant_id_o), NREQ));
      end
      // cnt holds the number of cycles elapsed since the tx_start_o pulse.
      case (state)
        START:   cnt <= CW'(1);
        WAIT:    cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
      if (state == IDLE && baud_div_i >= BAUD_MIN) begin
        baud_div_o <= baud_div_i;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: hand-written table of frames, corner
// sequences, then random frames against a transaction-level round-robin model.
module tb_uart_tx_arb;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_in;
  logic        tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] baud_out;
  logic        busy;
  logic [1:0]  grant;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr  = 0;
  int acc[4];
  int exp_acc[4];

  typedef struct {
    logic [3:0] v;
    int         d;
    int         g;
  } vec_t;
  vec_t tbl[10];

  uart_tx_arb_if #(.NREQ(4)) bus ();

  uart_tx_arb #(.NREQ(4), .TO_CYCLES(TO), .BAUD_RST(868)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req            (bus),
    .baud_div_i     (baud_in),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .baud_div_o     (baud_out),
    .tx_done_tick_i (tick),
    .busy_o         (busy),
    .grant_id_o     (grant),
    .done_o         (done),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.req_valid_i[k] && bus.req_ready_o[k]) acc[k]++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int j = 0; j < 4; j++) begin
      if (v[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  // Called in an IDLE cycle; d = WAIT cycle of the done tick (d >= TO: no tick).
  task automatic run_frame(input logic [3:0] v, input int d, input int g);
    logic [7:0] want_byte;
    want_byte = bus.req_data_i[8*g +: 8];
    bus.req_valid_i = v;
    #1;
    check("ready_onehot", int'(bus.req_ready_o), 1 << g);
    check("idle_at_accept", int'(busy), 0);
    nxt();
    check("start_pulse", int'(tx_start), 1);
    check("tx_data", int'(tx_data), int'(want_byte));
    check("grant_id", int'(grant), g);
    check("ready_outside_idle", int'(bus.req_ready_o), 0);
    if (d >= TO) begin
      for (int i = 1; i < TO; i++) begin
        nxt();
        if (i == 1) check("start_one_cycle", int'(tx_start), 0);
      end
      check("err_not_early", int'(err), 0);
      check("busy_in_wait", int'(busy), 1);
      nxt();
      check("err_pulse", int'(err), 1);
      check("no_done_on_timeout", int'(done), 0);
      check("idle_after_err", int'(busy), 0);
    end else begin
      for (int i = 1; i <= d; i++) nxt();
      tick = 1'b1;
      nxt();
      tick = 1'b0;
      check("done_pulse", int'(done), 1);
      check("no_err_on_done", int'(err), 0);
      check("idle_after_done", int'(busy), 0);
    end
    bus.req_valid_i = 4'b0000;
    exp_acc[g]++;
    m_ptr = (g + 1) % 4;
  endtask

  initial begin
    logic [3:0] rv;
    int         rd;
    int         g;
    int         pulses;

    tbl[0] = '{4'b1111,   5, 0};
    tbl[1] = '{4'b1111,   1, 1};
    tbl[2] = '{4'b1111,  20, 2};
    tbl[3] = '{4'b1111,  99, 3};
    tbl[4] = '{4'b1111,   7, 0};
    tbl[5] = '{4'b0001,   3, 0};
    tbl[6] = '{4'b1000, 200, 3};
    tbl[7] = '{4'b0110,  10, 1};
    tbl[8] = '{4'b0101,  98, 2};
    tbl[9] = '{4'b0011,   4, 0};

    // Reset, with requests pending to show ready stays low.
    rst = 1'b1;
    tick = 1'b0;
    baud_in = 16'd868;
    bus.req_valid_i = 4'b1111;
    bus.req_data_i = 32'h13121110;
    nxt();
    nxt();
    check("rst_ready", int'(bus.req_ready_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(tx_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_baud", int'(baud_out), 868);
    bus.req_valid_i = 4'b0000;
    rst = 1'b0;
    nxt();

    // Done tick in IDLE is ignored.
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    check("idle_tick_no_done", int'(done), 0);
    check("idle_tick_no_busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) run_frame(tbl[i].v, tbl[i].d, tbl[i].g);

    // Single request with byte AA; a tick during START must be ignored.
    bus.req_data_i[7:0] = 8'hAA;
    bus.req_valid_i = 4'b0001;
    #1;
    check("aa_ready", int'(bus.req_ready_o), 1);
    nxt();
    check("aa_start", int'(tx_start), 1);
    check("aa_data", int'(tx_data), 8'hAA);
    bus.req_valid_i = 4'b0000;
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    check("start_tick_no_done", int'(done), 0);
    check("start_tick_busy", int'(busy), 1);
    repeat (8) nxt();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    check("aa_done", int'(done), 1);
    exp_acc[0]++;
    m_ptr = 1;

    // Requester 2 pulses valid mid-frame and must never be served; baud held in WAIT.
    bus.req_valid_i = 4'b0001;
    #1;
    check("drop_ready", int'(bus.req_ready_o), 1);
    nxt();
    bus.req_valid_i = 4'b0100;
    nxt();
    bus.req_valid_i = 4'b0000;
    baud_in = 16'd434;
    nxt();
    check("baud_hold_wait", int'(baud_out), 868);
    repeat (3) nxt();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    check("drop_done", int'(done), 1);
    check("baud_hold_done_cycle", int'(baud_out), 868);
    exp_acc[0]++;
    m_ptr = 1;
    nxt();
    check("baud_load_idle", int'(baud_out), 434);
    baud_in = 16'd5;
    nxt();
    nxt();
    check("baud_ignore_5", int'(baud_out), 434);
    baud_in = 16'd15;
    nxt();
    check("baud_ignore_15", int'(baud_out), 434);
    baud_in = 16'd16;
    nxt();
    check("baud_load_16", int'(baud_out), 16);
    baud_in = 16'd500;
    nxt();
    check("baud_load_500", int'(baud_out), 500);
    run_frame(4'b0010, 6, pick(4'b0010, m_ptr));

    // Reset in WAIT abandons the frame silently.
    g = pick(4'b1000, m_ptr);
    bus.req_valid_i = 4'b1000;
    #1;
    check("mid_ready", int'(bus.req_ready_o), 1 << g);
    nxt();
    exp_acc[g]++;
    bus.req_valid_i = 4'b0000;
    nxt();
    nxt();
    check("mid_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick = 1'b1;
    bus.req_valid_i = 4'b1111;
    nxt();
    check("mid_rst_ready", int'(bus.req_ready_o), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_start", int'(tx_start), 0);
    check("mid_rst_data", int'(tx_data), 0);
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_baud", int'(baud_out), 868);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_err", int'(err), 0);
    rst = 1'b0;
    bus.req_valid_i = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      tick = 1'b0;
      pulses += int'(done) + int'(err);
    end
    check("mid_rst_no_pulse", pulses, 0);
    m_ptr = 0;

    // Random frames against the round-robin model.
    for (int i = 0; i < 25; i++) begin
      rv = 4'($urandom_range(1, 15));
      rd = int'($urandom_range(1, 110));
      bus.req_data_i = $urandom;
      run_frame(rv, rd, pick(rv, m_ptr));
    end

    nxt();
    for (int k = 0; k < 4; k++) check("accept_count", acc[k], exp_acc[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
